delay_prog: RTL
===============

# delay_prog

Runtime-programmable delay line: delays a WIDTH-bit sample stream by a number of enabled clock cycles. The delay is loaded while the design runs, anywhere from 0 to MAX_LENGTH. This block is the successor to the fixed-length `delay`. It adds runtime length changes, a fill/valid indication, a synchronous flush and length-error reporting. It sits in datapaths that need a tunable alignment between two streams, for example matching pipeline skew after calibration.

## Interface
- `WIDTH`, 8 — sample width in bits.
- `MAX_LENGTH`, 16 — largest supported delay. Must be ≥1. This is also the storage depth.
- `DEFAULT_LENGTH`, 4 — delay in effect after reset. Must be ≤ MAX_LENGTH.
- `LEN_W`, $clog2(MAX_LENGTH+1) — width of the length port. Derived; do not override.

Ports:
- `clk`  in  1 — clock. All logic is rising-edge.
- `rst`  in  1 — asynchronous, active-high reset.
- `ena`  in  1 — clock enable. The line advances only on edges where `ena`=1.
- `flush`  in  1 — synchronous. Discards accumulated history; takes effect regardless of `ena`.
- `len_we`  in  1 — synchronous strobe that loads `len_in`; takes effect regardless of `ena`.
- `len_in`  in  LEN_W — requested delay.
- `in`  in  WIDTH — input sample.
- `out`  out  WIDTH — delayed sample. Forced to 0 while `out_valid`=0.
- `out_valid`  out  1 — high once `len` samples have been captured since the last reset, flush or length load.
- `len`  out  LEN_W — delay currently in effect.
- `len_err`  out  1 — one-cycle pulse when `len_in` > MAX_LENGTH was written.

## Operation
- Storage is a ring buffer `mem[0..MAX_LENGTH-1]` of WIDTH bits.
  - Write pointer `wp` wraps from MAX_LENGTH-1 to 0.
  - The ring buffer is not reset, so its contents are X after power-up.
- Enabled edge behaviour:
  - `mem[wp] <= in`, then `wp <= wp+1 mod MAX_LENGTH`.
  - `fill <= min(fill+1, len)`.
- Read address is `(wp - len) mod MAX_LENGTH`, read asynchronously.
  - Net effect: `out` equals the `in` captured exactly `len` enabled edges earlier, identical to a `len`-stage shift register.
- `out_valid = (fill == len)`. `out = out_valid ? mem[rd] : 0`.
- Zero-length mode (`len`=0):
  - `out = in` combinationally and `out_valid` = 1.
  - Writes to the buffer continue normally.
- Length load (`len_we`=1):
  - `len <= min(len_in, MAX_LENGTH)` and `fill <= 0`.
  - `len_err <= (len_in > MAX_LENGTH)` for one cycle.
  - `wp` is not disturbed.
- Flush (`flush`=1): `fill <= 0`. `wp`, `len` and the buffer are unchanged.
- Simultaneous events:
  - `len_we` and `flush` together: the length loads and `fill` = 0.
  - Either of them together with `ena`: the sample is still written and `fill` ends at 0, not 1. The sample written on that edge does not count toward fill.
- Reset values: `wp`=0, `fill`=0, `len`=DEFAULT_LENGTH, `len_err`=0, `out_valid`=0 (1 if DEFAULT_LENGTH=0), `out`=0.
- Reset asserted mid-stream: all of the above apply immediately and asynchronously. History is discarded.

## Timing
- Latency: `len` enabled edges, from the edge that captures `in` to `out` showing it.
- `out` and `out_valid` are combinational from registers. They settle after the clock edge and have no path from `in`, except when `len`=0.
- After reset, flush or a length load, `out_valid` rises after the `len`-th subsequent enabled edge.
  - Non-enabled edges do not count toward this.
- `len` updates on the edge following the `len_we` cycle. `len_err` is high for exactly the cycle after that edge.
- With `ena`=0, `out` holds its value indefinitely.

## Structure
- Shared package `delay_pkg`:
  - `function automatic int len_w(int max_len)` returning $clog2(max_len+1).
  - Pointer-wrap helper `ptr_sub(wp, len, depth)`.
- One sub-module: `delay_prog_mem`.
  - WIDTH × MAX_LENGTH register array.
  - One write port with enable, one asynchronous read port.
- The top level holds the pointer, fill counter, length register and output gating.

## Test plan
- Reset default, WIDTH=8, MAX_LENGTH=16, DEFAULT_LENGTH=4, ena=1, `in`=1,2,3,…:
  - `out_valid` is 0 for the first 3 cycles after the first enabled edge.
  - After the 4th edge, `out_valid`=1 and `out`=1, then 2, 3, … each cycle.
- Enable stall: stream as above, `ena` low for 5 cycles after `out`=3.
  - `out` holds 3 for 5 cycles, then continues at 4. No sample is dropped or duplicated.
- Length change: at steady state with `len`=4, pulse `len_we` with `len_in`=10.
  - `out_valid` drops next cycle and rises after 10 enabled edges.
  - `out` then lags `in` by exactly 10. Repeat with a decrease to 2.
- Wrap and maximum length: `len_in`=16, run 40 samples.
  - `out[n]` = `in[n-16]` across the pointer wrap.
- Error and clamp: `len_in`=20.
  - `len_err` pulses once and `len` reads 16.
  - `len_in`=0 gives `out`==`in` in the same cycle with `out_valid`=1.
- Flush plus async reset: flush at steady state, which drops `out_valid` for `len` edges.
  - Raise `rst` mid-cycle: `out`=0 and `len`=4 immediately, before the next clock edge.

Source files
------------

// File: rtl/delay_pkg.sv
// delay_pkg: shared helpers for the programmable delay line.
//   len_w   - width needed to hold a length in the range 0..max_len
//   ptr_sub - ring-buffer pointer subtraction, (wp - len) mod depth
package delay_pkg;

    function automatic int len_w(int max_len);
        return $clog2(max_len + 1);
    endfunction

    // len may equal depth, so a single wrap correction is always enough.
    function automatic int ptr_sub(int wp, int len, int depth);
        int d;
        d = wp - len;
        if (d < 0) d = d + depth;
        return d;
    endfunction

endpackage

// File: rtl/delay_prog_mem.sv
// delay_prog_mem: WIDTH x DEPTH register array, not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - asynchronous read data
module delay_prog_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/delay_prog.sv
// delay_prog: runtime-programmable delay line (0..MAX_LENGTH enabled cycles).
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   ena        - clock enable for the sample stream
//   flush      - discard history (fill back to 0)
//   len_we     - load len_in as the new delay
//   len_in     - requested delay, clamped to MAX_LENGTH
//   in / out   - sample input / delayed sample (0 while not valid)
//   out_valid  - line holds len samples since last reset/flush/load
//   len        - delay in effect
//   len_err    - one-cycle pulse after a too-large len_in was written
module delay_prog
    import delay_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int MAX_LENGTH     = 16,
    parameter int DEFAULT_LENGTH = 4,
    parameter int LEN_W          = len_w(MAX_LENGTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             flush,
    input  logic             len_we,
    input  logic [LEN_W-1:0] len_in,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [LEN_W-1:0] len,
    output logic             len_err
);

    localparam int PTR_W = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;

    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rd_addr;
    logic [LEN_W-1:0] fill;
    logic [WIDTH-1:0] rd_data;
    logic             len_over;
    logic [LEN_W-1:0] len_clamped;

    assign len_over    = int'(len_in) > MAX_LENGTH;
    assign len_clamped = len_over ? LEN_W'(MAX_LENGTH) : len_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp      <= '0;
            fill    <= '0;
            len     <= LEN_W'(DEFAULT_LENGTH);
            len_err <= 1'b0;
        end else begin
            len_err <= len_we && len_over;
            if (len_we) len <= len_clamped;

            if (ena) begin
                wp <= (wp == PTR_W'(MAX_LENGTH - 1)) ? '0 : wp + 1'b1;
            end

            // A sample written alongside flush/load does not count toward fill.
            if (len_we || flush) begin
                fill <= '0;
            end else if (ena && (fill < len)) begin
                fill <= fill + 1'b1;
            end
        end
    end

    assign rd_addr = PTR_W'(ptr_sub(int'(wp), int'(len), MAX_LENGTH));

    delay_prog_mem #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_LENGTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (ena),
        .waddr (wp),
        .wdata (in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // len = 0 gives fill == len, so out_valid is 1 and the input bypasses the buffer.
    assign out_valid = (fill == len);
    assign out       = (len == '0) ? in : (out_valid ? rd_data : '0);

endmodule
